// File: rtl/viterbi_pkg.sv
// Shared types and constants for the convolutional encoder and the Viterbi decoder.
// Optional feature macro: CONV_ENC_TAIL_EN (adds the two tail-termination states).
package viterbi_pkg;

    localparam int unsigned K = 3;

    // Generator taps: bit2 = current input, bit1 = sr[1], bit0 = sr[0]
    localparam logic [K-1:0] G0_DEFAULT = 3'b111;
    localparam logic [K-1:0] G1_DEFAULT = 3'b101;

    typedef logic [1:0] sym_t;

    typedef enum logic [1:0] {
        S_DATA  = 2'd0
`ifdef CONV_ENC_TAIL_EN
        ,
        S_TAIL0 = 2'd1,
        S_TAIL1 = 2'd2
`endif
    } enc_state_t;

endpackage

// File: rtl/conv_encoder_if.sv
// Framed bit-in / symbol-out stream bundle for conv_encoder.
// master = stream source and sink (bench / neighbours), slave = the encoder.
interface conv_encoder_if;
    import viterbi_pkg::*;

    logic in_valid;
    logic in_ready;
    logic in_bit;
    logic in_last;
    logic out_valid;
    logic out_ready;
    sym_t out_sym;
    logic out_last;

    modport master (
        output in_valid, in_bit, in_last, out_ready,
        input  in_ready, out_valid, out_sym, out_last
    );

    modport slave (
        input  in_valid, in_bit, in_last, out_ready,
        output in_ready, out_valid, out_sym, out_last
    );

endinterface

// File: rtl/conv_enc_sym.sv
// Combinational code-symbol generator: (u, sr) -> {c0, c1}.
// Shared with the decoder's branch-metric unit for expected-symbol generation.
module conv_enc_sym
    import viterbi_pkg::*;
#(
    parameter logic [K-1:0] G0 = G0_DEFAULT,
    parameter logic [K-1:0] G1 = G1_DEFAULT
) (
    input  logic         u,
    input  logic [K-2:0] sr,
    output sym_t         sym
);

    logic [K-1:0] taps;

    // Parity of the tapped {u, sr} window for each generator
    always_comb begin
        taps = {u, sr};
        sym  = {^(G0 & taps), ^(G1 & taps)};
    end

endmodule

// File: rtl/conv_encoder.sv
// Rate-1/2, K=3 convolutional encoder with a single-entry output register.
// Optional feature macro: CONV_ENC_TAIL_EN -- when defined each frame is followed
// by two zero tail bits (N+2 symbols); otherwise out_last rides on the last data
// symbol and sr is cleared on the in_last handshake (N symbols).
module conv_encoder
    import viterbi_pkg::*;
#(
    parameter logic [K-1:0] G0    = G0_DEFAULT,
    parameter logic [K-1:0] G1    = G1_DEFAULT,
    parameter int unsigned  CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    conv_encoder_if.slave    bus,
    output logic [CNT_W-1:0] frame_syms,
    output logic             busy
);

    enc_state_t   state;
    logic [K-2:0] sr;
    logic         valid_reg;
    logic         last_reg;
    sym_t         sym_reg;

    logic         load_ok;
    logic         in_fire;
    logic         out_fire;
    logic         enc_u;
    sym_t         enc_out;

    assign bus.in_ready  = (state == S_DATA) && load_ok;
    assign bus.out_valid = valid_reg;
    assign bus.out_sym   = sym_reg;
    assign bus.out_last  = last_reg;

    // Handshake qualifiers and the bit fed to the encoder (zero during the tail)
    always_comb begin
        load_ok  = !valid_reg || bus.out_ready;
        in_fire  = bus.in_valid && (state == S_DATA) && load_ok;
        out_fire = valid_reg && bus.out_ready;
        enc_u    = (state == S_DATA) ? bus.in_bit : 1'b0;
        busy     = (state != S_DATA) || valid_reg;
    end

    conv_enc_sym #(
        .G0 (G0),
        .G1 (G1)
    ) u_sym (
        .u   (enc_u),
        .sr  (sr),
        .sym (enc_out)
    );

    // Framing FSM, shift register and the registered output symbol
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_DATA;
            sr        <= '0;
            valid_reg <= 1'b0;
            sym_reg   <= '0;
            last_reg  <= 1'b0;
        end else begin
            // A new load below overrides this drop of the accepted symbol
            if (out_fire) begin
                valid_reg <= 1'b0;
            end
            case (state)
                S_DATA: begin
                    if (in_fire) begin
                        valid_reg <= 1'b1;
                        sym_reg   <= enc_out;
`ifdef CONV_ENC_TAIL_EN
                        last_reg  <= 1'b0;
                        sr        <= {enc_u, sr[1]};
                        if (bus.in_last) begin
                            state <= S_TAIL0;
                        end
`else
                        last_reg  <= bus.in_last;
                        sr        <= bus.in_last ? '0 : {enc_u, sr[1]};
`endif
                    end
                end
`ifdef CONV_ENC_TAIL_EN
                S_TAIL0: begin
                    if (load_ok) begin
                        valid_reg <= 1'b1;
                        sym_reg   <= enc_out;
                        last_reg  <= 1'b0;
                        sr        <= {1'b0, sr[1]};
                        state     <= S_TAIL1;
                    end
                end
                S_TAIL1: begin
                    if (load_ok) begin
                        valid_reg <= 1'b1;
                        sym_reg   <= enc_out;
                        last_reg  <= 1'b1;
                        sr        <= {1'b0, sr[1]};
                        state     <= S_DATA;
                    end
                end
`endif
                default: begin
                    state <= S_DATA;
                end
            endcase
        end
    end

    // Per-frame symbol counter: saturating, cleared by the out_last handshake
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_syms <= '0;
        end else if (out_fire) begin
            if (last_reg) begin
                frame_syms <= '0;
            end else if (frame_syms != '1) begin
                frame_syms <= frame_syms + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_conv_encoder.sv
// Self-checking bench for conv_encoder: directed frame table, timing/stall/reset
// sequences, and random frames against a zero-padded sliding-window parity model.
// Honours CONV_ENC_TAIL_EN the same way as the design.
module tb_conv_encoder;
    import viterbi_pkg::*;

    localparam int unsigned CNT_W = 3;
    localparam logic [2:0]  G0    = 3'b111;
    localparam logic [2:0]  G1    = 3'b101;
`ifdef CONV_ENC_TAIL_EN
    localparam int TAIL = 2;
`else
    localparam int TAIL = 0;
`endif

    typedef struct {
        sym_t sym;
        logic last;
    } exp_t;

    typedef struct {
        int          n;
        logic [7:0]  bits;
        logic [11:0] syms;
    } vec_t;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [CNT_W-1:0] frame_syms;
    logic             busy;

    conv_encoder_if bus ();

    conv_encoder #(
        .G0    (G0),
        .G1    (G1),
        .CNT_W (CNT_W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus),
        .frame_syms (frame_syms),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    exp_t             exp_q[$];
    vec_t             vecs[4];
    int unsigned      checks = 0;
    int unsigned      errors = 0;
    int               cyc = 0;
    int               rdy_mode = 0;   // 0 ready high, 1 random, 2 held low
    logic [CNT_W-1:0] mcount = '0;
    logic             held = 1'b0;
    sym_t             hsym;
    logic             hlast;
    exp_t             mon_e;

    task automatic check_eq(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name, input logic [31:0] act);
        checks++;
        errors++;
        $display("FAIL %s: got %0h expected none", name, act);
    endtask

    // Symbol k is the generator parity over input bits k, k-1, k-2 (zero outside the frame)
    task automatic push_model(input int n, input logic [31:0] bits);
        logic [2:0] win;
        exp_t       e;
        int         idx;
        for (int k = 0; k < n + TAIL; k++) begin
            for (int j = 0; j < 3; j++) begin
                idx = k - j;
                if (idx >= 0 && idx < n) win[2-j] = bits[idx];
                else                     win[2-j] = 1'b0;
            end
            e.sym  = {^(win & G0), ^(win & G1)};
            e.last = (k == n + TAIL - 1);
            exp_q.push_back(e);
        end
    endtask

    task automatic push_table(input int i);
        exp_t e;
        int   nsym;
        nsym = vecs[i].n + TAIL;
        for (int k = 0; k < nsym; k++) begin
            e.sym  = vecs[i].syms[2*k +: 2];
            e.last = (k == nsym - 1);
            exp_q.push_back(e);
        end
    endtask

    task automatic send_bit(input logic b, input logic l);
        int guard;
        guard = 0;
        bus.in_valid = 1'b1;
        bus.in_bit   = b;
        bus.in_last  = l;
        @(negedge clk);
        while (!bus.in_ready && guard < 200) begin
            guard++;
            @(negedge clk);
        end
        if (guard >= 200) fail_now("in_ready_timeout", 32'(bus.in_ready));
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    task automatic send_frame(input int n, input logic [31:0] bits, input bit gaps);
        for (int i = 0; i < n; i++) begin
            if (gaps && $urandom_range(0, 3) == 0) begin
                @(posedge clk);
                #1;
            end
            send_bit(bits[i], i == n - 1);
        end
    endtask

    task automatic wait_drain();
        int guard;
        guard = 0;
        while ((exp_q.size() != 0 || bus.out_valid) && guard < 500) begin
            @(posedge clk);
            #1;
            guard++;
        end
        if (guard >= 500) fail_now("drain_timeout", exp_q.size());
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Downstream ready driver
    initial forever begin
        @(posedge clk);
        #2;
        case (rdy_mode)
            0:       bus.out_ready = 1'b1;
            1:       bus.out_ready = ($urandom_range(0, 3) != 0);
            default: bus.out_ready = 1'b0;
        endcase
    end

    // Output monitor: scoreboard, frame counter model, hold-while-stalled
    initial forever begin
        @(negedge clk);
        if (!rst_n) begin
            held   = 1'b0;
            mcount = '0;
            exp_q.delete();
        end else begin
            if (held) begin
                check_eq("hold_valid", 32'(bus.out_valid), 32'd1);
                check_eq("hold_sym", 32'(bus.out_sym), 32'(hsym));
                check_eq("hold_last", 32'(bus.out_last), 32'(hlast));
            end
            if (bus.out_valid && bus.out_ready) begin
                held = 1'b0;
                if (exp_q.size() == 0) begin
                    fail_now("unexpected_sym", 32'(bus.out_sym));
                end else begin
                    mon_e = exp_q.pop_front();
                    check_eq("sym", 32'(bus.out_sym), 32'(mon_e.sym));
                    check_eq("last", 32'(bus.out_last), 32'(mon_e.last));
                    check_eq("frame_syms", 32'(frame_syms), 32'(mcount));
                    if (mon_e.last)         mcount = '0;
                    else if (mcount != '1)  mcount = mcount + 1'b1;
                end
            end else if (bus.out_valid) begin
                held  = 1'b1;
                hsym  = bus.out_sym;
                hlast = bus.out_last;
            end else begin
                held = 1'b0;
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected completion");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1, "time limit reached");
    end

    initial begin
        int s;
        int n;
        logic [31:0] bits;

        bus.in_valid = 1'b0;
        bus.in_bit   = 1'b0;
        bus.in_last  = 1'b0;
        bus.out_ready = 1'b1;

`ifdef CONV_ENC_TAIL_EN
        vecs[0] = '{n: 4, bits: 8'b0000_1101, syms: 12'b11_01_01_00_10_11};
        vecs[1] = '{n: 1, bits: 8'b0000_0001, syms: 12'b00_00_00_11_10_11};
        vecs[2] = '{n: 2, bits: 8'b0000_0011, syms: 12'b00_00_11_01_01_11};
        vecs[3] = '{n: 2, bits: 8'b0000_0001, syms: 12'b00_00_00_11_10_11};
`else
        vecs[0] = '{n: 4, bits: 8'b0000_1101, syms: 12'b00_00_01_00_10_11};
        vecs[1] = '{n: 1, bits: 8'b0000_0001, syms: 12'b00_00_00_00_00_11};
        vecs[2] = '{n: 2, bits: 8'b0000_0011, syms: 12'b00_00_00_00_01_11};
        vecs[3] = '{n: 2, bits: 8'b0000_0001, syms: 12'b00_00_00_00_10_11};
`endif

        // Reset state
        #12;
        check_eq("rst_in_ready", 32'(bus.in_ready), 32'd1);
        check_eq("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check_eq("rst_out_sym", 32'(bus.out_sym), 32'd0);
        check_eq("rst_out_last", 32'(bus.out_last), 32'd0);
        check_eq("rst_frame_syms", 32'(frame_syms), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Directed frame table; entries 2 and 3 go back-to-back
        for (int i = 0; i < 4; i++) begin
            if (i == 2) begin
                wait_drain();
                s = cyc;
            end
            push_table(i);
            send_frame(vecs[i].n, 32'(vecs[i].bits), 1'b0);
            if (i == 3) check_eq("b2b_cycles", 32'(cyc - s), 32'(4 + TAIL));
        end
        wait_drain();
        check_eq("idle_frame_syms", 32'(frame_syms), 32'd0);
        check_eq("idle_busy", 32'(busy), 32'd0);

        // Single-bit frame: latency and in_ready gap after in_last
        push_table(1);
        send_bit(1'b1, 1'b1);
        @(negedge clk);
        check_eq("latency_valid", 32'(bus.out_valid), 32'd1);
        check_eq("first_sym", 32'(bus.out_sym), 32'd3);
        check_eq("busy_after_last", 32'(busy), 32'd1);
        check_eq("in_ready_t1", 32'(bus.in_ready), 32'(TAIL == 0));
        @(negedge clk);
        check_eq("in_ready_t2", 32'(bus.in_ready), 32'(TAIL == 0));
        @(negedge clk);
        check_eq("in_ready_t3", 32'(bus.in_ready), 32'd1);
        @(posedge clk);
        #1;
        wait_drain();

        // Three-cycle backpressure stall mid-frame; stream must match the table
        push_table(0);
        fork
            send_frame(vecs[0].n, 32'(vecs[0].bits), 1'b0);
            begin : stall_ctl
                int g;
                g = 0;
                @(negedge clk);
                while (!bus.out_valid && g < 50) begin
                    g++;
                    @(negedge clk);
                end
                if (g >= 50) fail_now("stall_start_timeout", 32'(bus.out_valid));
                @(posedge clk);
                #1;
                rdy_mode = 2;
                @(posedge clk);
                #1;
                for (int c = 0; c < 3; c++) begin
                    @(negedge clk);
                    check_eq("stall_in_ready", 32'(bus.in_ready), 32'd0);
                    check_eq("stall_out_valid", 32'(bus.out_valid), 32'd1);
                end
                rdy_mode = 0;
            end
        join
        wait_drain();

        // Long frame drives the narrow frame counter into saturation
        push_model(10, 32'h3A5);
        send_frame(10, 32'h3A5, 1'b0);
        wait_drain();

        // Reset mid-frame discards the pending symbol and restarts from sr = 00
`ifdef CONV_ENC_TAIL_EN
        push_model(2, 32'b11);
        send_bit(1'b1, 1'b0);
        send_bit(1'b1, 1'b1);
`else
        push_model(2, 32'b01);
        send_bit(1'b1, 1'b0);
        send_bit(1'b0, 1'b0);
`endif
        rst_n = 1'b0;
        #1;
        check_eq("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
        check_eq("mid_rst_busy", 32'(busy), 32'd0);
        check_eq("mid_rst_frame_syms", 32'(frame_syms), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        push_table(1);
        send_frame(1, 32'd1, 1'b0);
        wait_drain();

        // Random frames with random gaps and random backpressure
        rdy_mode = 1;
        for (int f = 0; f < 40; f++) begin
            n    = $urandom_range(1, 10);
            bits = $urandom;
            push_model(n, bits);
            send_frame(n, bits, 1'b1);
        end
        wait_drain();
        rdy_mode = 0;
        @(posedge clk);
        #1;
        check_eq("end_frame_syms", 32'(frame_syms), 32'd0);
        check_eq("end_busy", 32'(busy), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/conv_encoder.md
# conv_encoder

Rate-1/2, constraint-length-3 convolutional encoder with tail-bit termination. It is the transmit-side counterpart of the Viterbi decoder: it produces the 2-bit code symbols whose branch metrics the decoder's add-compare-select stage scores. Input is a framed serial bit stream and output is a framed symbol stream, both with valid/ready handshakes. Each frame is terminated so the trellis returns to state 0, which the decoder's traceback requires.

## Interface
- G0 — 3'b111 — generator 0 taps; bit2 = current input, bit1 = sr[1], bit0 = sr[0]
- G1 — 3'b101 — generator 1 taps, same bit mapping
- CNT_W — 16 — width of frame_syms
- clk  in  1  clock; all state updates on its rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  in_bit/in_last valid
- in_ready  out  1  encoder accepts a bit this cycle
- in_bit  in  1  data bit
- in_last  in  1  final data bit of the frame
- out_valid  out  1  out_sym/out_last valid
- out_ready  in  1  downstream accepts the symbol
- out_sym  out  2  {c0, c1}; c0 = ^(G0 & {u,sr}), c1 = ^(G1 & {u,sr})
- out_last  out  1  final symbol of the frame
- frame_syms  out  CNT_W  symbols handshaken so far in the current frame
- busy  out  1  state != S_DATA or out_valid

## Operation
- Encoder state is sr[1:0], where sr[1] is the most recent bit. On each encoded bit u, the next sr is {u, sr[1]}.
- FSM states: S_DATA, S_TAIL0, S_TAIL1.
- Output is a single-entry register. It loads when (!out_valid || out_ready), called "load_ok".
- in_ready = (state == S_DATA) && load_ok. This is combinational from registered state, so in_ready is 1 out of reset.
- S_DATA, on an input handshake: encode in_bit, load the output register, set out_last = 0.
  - If in_last: go to S_TAIL0.
- S_TAIL0, when load_ok: encode u = 0, load the output register with out_last = 0, go to S_TAIL1.
- S_TAIL1, when load_ok: encode u = 0, load the output register with out_last = 1, go to S_DATA. sr is now 00.
- An N-bit frame produces exactly N+2 symbols.
- When out_valid && !out_ready, out_sym and out_last hold stable.
- frame_syms:
  - Increments on each output handshake and saturates at all-ones.
  - Clears to 0 on the handshake of the out_last symbol; the clear takes priority over the increment.
- Reset values: state = S_DATA, sr = 00, out_valid = 0, out_sym = 00, out_last = 0, frame_syms = 0, busy = 0.
- Reset asserted mid-frame discards the partial frame and any pending symbol. The next frame starts from sr = 00.

## Timing
- Latency: an input handshake in cycle t gives out_valid in cycle t+1.
- Throughput: 1 bit/symbol per cycle with out_ready held high.
- After in_last is accepted in cycle t, with out_ready high:
  - in_ready = 0 in cycles t+1 and t+2.
  - Tail symbols are presented in cycles t+2 and t+3.
  - The next frame's first bit can be accepted in cycle t+3.
- Backpressure stalls the tail states. There is no symbol loss or duplication.

## Configuration
- CONV_ENC_TAIL_EN defined: tail termination as described above; N+2 symbols per frame.
- CONV_ENC_TAIL_EN undefined:
  - S_TAIL0 and S_TAIL1 are removed.
  - out_last is asserted on the symbol of the in_last bit.
  - sr is cleared to 00 on the in_last handshake.
  - N symbols per frame; in_ready never deasserts between frames.

## Structure
- viterbi_pkg holds:
  - K = 3
  - typedef sym_t (logic [1:0])
  - default G0/G1 constants, shared with the decoder's expected-symbol generation
  - enc_state_t enum
- Sub-module conv_enc_sym: combinational (u, sr, G0, G1) -> sym_t. It is reusable by the decoder's branch-metric unit.

## Test plan
- Frame 1,0,1,1 (last on 4th), out_ready = 1 → symbols 11,10,00,01,01,11; out_last only on the 6th; frame_syms reads 1..5, then 0 after the 6th handshake.
- Single-bit frame: in_bit = 1 with last → 11,10,11; in_ready low exactly 2 cycles; out_last on the 3rd symbol.
- out_ready low for 3 cycles mid-frame → out_sym stable, in_ready = 0, stream unchanged versus the unstalled run.
- Back-to-back frames 1,1(last) then 1,0(last) → 11,01,01,11 then 11,10,11,00 (per-frame out_last on the 4th symbol), no gap beyond the 2 tail cycles.
- rst_n pulsed low during S_TAIL0 → out_valid = 0 immediately; a following frame 1(last) gives 11,10,11.
- CONV_ENC_TAIL_EN undefined, frame 1,0,1,1 then 1 (each last-terminated) → 11,10,00,01 (last), then 11 (last).
